// File: rtl/ins2sp_pkg.sv
// ins2sp_pkg
// Shared definitions for the instruction-to-SP datapath (divider and
// sequential multiply-add unit).
//   INS2SP_WIDTH : default operand width used by both arithmetic units
//   state_e      : control states of the sequential multiply-add unit
package ins2sp_pkg;

  localparam int INS2SP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : ins2sp_pkg

// File: rtl/seq_muladd.sv
// seq_muladd
// Sequential unsigned multiply-add: product = a * b + c, computed with a
// radix-2 shift-add loop that retires one multiplier bit per clock. Feeding
// it (quotient, divisor, remainder) from the ins2sp divider rebuilds the
// dividend. Latency is always WIDTH cycles from acceptance to out_valid.
//
// Ports
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : a, b, c are valid
//   in_ready  : unit accepts operands (IDLE only)
//   a         : multiplier, WIDTH bits, unsigned
//   b         : multiplicand, WIDTH bits, unsigned
//   c         : addend, WIDTH bits, unsigned (zero-extended)
//   out_valid : product holds a completed result (DONE)
//   out_ready : consumer takes the result
//   product   : a*b + c, 2*WIDTH bits; only meaningful while out_valid=1
module seq_muladd
  import ins2sp_pkg::*;
#(
  parameter int WIDTH = INS2SP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state;
  state_e             state_d;
  logic [WIDTH-1:0]   mplr;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  // Next-state logic. The loop never terminates early: exactly WIDTH RUN
  // cycles, so the latency does not depend on operand values.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid)         state_d = RUN;
      RUN:     if (cnt == CNT_LAST)  state_d = DONE;
      DONE:    if (out_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // State register plus shift-add datapath. The accumulator cannot overflow:
  // the largest result is 2^(2W) - 2^W, so no carry out exists.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, because product must read 0
    // immediately on reset; everything here uses <= so all reads see the
    // pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      mplr  <= '0;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mplr  <= a;
            mcand <= {{WIDTH{1'b0}}, b};
            acc   <= {{WIDTH{1'b0}}, c};
            cnt   <= '0;
          end
        end
        RUN: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
        end
        default: ;  // DONE: hold result until the consumer takes it
      endcase
    end
  end

  // Handshake outputs decode the state register only (no input-to-output path).
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = acc;

endmodule : seq_muladd
